ysyx_25020037_axi_arbiter: RTL and testbench
============================================

# ysyx_25020037_axi_arbiter

Two-master to one-slave AXI4 arbiter sitting directly upstream of the SRAM slave. Master 0 is the instruction fetch unit (read-only), master 1 is the load/store unit (read and write). The arbiter serialises transactions so the slave sees at most one outstanding transaction at a time. It routes response channels back to the granted master only.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- m0_ar{valid,addr,id,len,size,burst}  in  1/32/4/8/3/2  IFU read address
- m0_arready  out  1  IFU read address ready
- m0_r{valid,resp,data,last,id}  out  1/2/32/1/4  IFU read data
- m0_rready  in  1  IFU read data ready
- m1_ar*, m1_r*  same shapes and directions as m0  LSU read channels
- m1_aw{valid,addr,id,len,size,burst}  in  1/32/4/8/3/2  LSU write address
- m1_awready  out  1
- m1_w{valid,data,strb,last}  in  1/32/4/1  LSU write data
- m1_wready  out  1
- m1_b{valid,resp,id}  out  1/2/4  LSU write response
- m1_bready  in  1
- s_ar*, s_aw*, s_w*  out (ready in)  mirror of the above toward the slave
- s_r*, s_b*  in (ready out)  slave responses

## Operation
- States: IDLE, GRANT_M0_RD, GRANT_M1_RD, GRANT_M1_WR (2-bit register).
- IDLE: sample requests. Requests are req0=m0_arvalid, req1r=m1_arvalid, req1w=m1_awvalid.
- Without the config macro, priority is M1_WR > M1_RD > M0_RD. With the macro, priority follows the Configuration section.
- All master readys and slave valids are 0 in IDLE.
- Grant state: forward only the granted master's request channels and the matching response channel, combinationally (valid/payload one way, ready the other). All other master readys, and all other slave valids and readys, are held at 0.
- Done flags ar_done, aw_done and w_done are set on the respective handshake. Once a flag is set, the forwarded valid is masked to 0. This makes the arbiter tolerate a slave whose ready is held high.
- Read grant ends on an R handshake with rlast=1. Earlier R beats are forwarded, and the grant is held.
- Write grant ends on a B handshake. The arbiter accepts the W beat before or after AW. B is only forwarded once both aw_done and w_done are set. A B arriving earlier is held off with bready=0.
- At grant end: next state is IDLE, done flags clear, last_grant is updated.
- Payloads are not modified. Ids are passed through unchanged.

## Timing
- Reset (async assert, sync release): state=IDLE, all flags=0, last_grant=M0, all outputs 0.
- Request seen in IDLE at cycle N → grant state at N+1, with slave valid asserted at N+1.
- Arbitration adds exactly 1 cycle of latency per transaction. There is a 1-cycle IDLE bubble between back-to-back transactions.
- Requests that arrive while another master is granted wait. Their readys stay 0, and their valid must stay asserted per AXI.
- Simultaneous requests in IDLE are resolved by the priority rule in that same IDLE cycle.
- Reset asserted mid-transaction: everything returns to IDLE immediately and the in-flight transaction is discarded.
- Final handshake and a new request in the same cycle: the new request is not granted until the following IDLE cycle.

## Configuration
- ARB_RR_EN defined: round-robin between M0 and M1. On contention, the master that was not last_grant wins. M1 write beats M1 read within M1.
- ARB_RR_EN undefined: fixed priority as in Operation. The last_grant register is removed.

## Structure
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, GRANT_M0_RD=2'd1, GRANT_M1_RD=2'd2, GRANT_M1_WR=2'd3)
  - AXI resp codes (OKAY=2'b00)
  - ADDR_W and DATA_W defaults
- One sub-module is natural: ysyx_25020037_arb_pick, the combinational grant selector. Inputs are requests and last_grant; the output is the next state. It contains the ARB_RR_EN logic.
- Channel muxing and done flags stay in the top module.

## Test plan
- M0 reads 0x80000000 alone: grant at N+1, s_araddr=0x80000000, r data 0x00000413 returned on m0_r with rlast → IDLE. m1_rvalid stays 0 throughout.
- M1 writes 0x80001000, data 0xDEADBEEF, strb 0xF. AW is presented at N and W at N+3. Required: s_wvalid only once W is presented, m1_bvalid after both handshakes, bresp=0.
- M0 and M1 reads both asserted in the same IDLE cycle, fixed priority: M1 is served first, then M0 after one IDLE cycle. With ARB_RR_EN and last_grant=M1: M0 is served first.
- Slave arready tied high: exactly one AR handshake per grant, and s_arvalid drops the cycle after the handshake.
- 4-beat read burst (arlen=3) from M1: all 4 beats reach m1 in order, and the grant is released only after the beat with rlast=1.
- rst_n pulsed low mid-write after the AW handshake: all outputs go 0 immediately and state=IDLE. A subsequent M0 read completes normally.

Source files
------------

// File: rtl/ysyx_25020037_axi_arbiter_pkg.sv
// Shared definitions for the two-master AXI4 arbiter.
// Optional feature macro: ARB_RR_EN (round-robin between M0 and M1).
package ysyx_25020037_axi_arbiter_pkg;

  // Arbiter state encoding (2-bit state register)
  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] GRANT_M0_RD = 2'd1;
  localparam logic [1:0] GRANT_M1_RD = 2'd2;
  localparam logic [1:0] GRANT_M1_WR = 2'd3;

  // Identity of the master that held the most recent grant
  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Default bus widths
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/ysyx_25020037_arb_pick.sv
// Combinational grant selector: maps the pending requests seen in IDLE
// to the grant state entered on the next clock.
// With ARB_RR_EN defined, M0 and M1 alternate on contention; otherwise
// fixed priority M1 write > M1 read > M0 read.
module ysyx_25020037_arb_pick
  import ysyx_25020037_axi_arbiter_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic       last_grant,
`endif
  input  logic       req0,
  input  logic       req1r,
  input  logic       req1w,
  output logic [1:0] next_state
);

`ifdef ARB_RR_EN
  // Round-robin between masters; within M1 the write wins over the read
  always_comb begin
    next_state = IDLE;
    if (req0 && (req1r || req1w)) begin
      if (last_grant == GNT_M1) begin
        next_state = GRANT_M0_RD;
      end else if (req1w) begin
        next_state = GRANT_M1_WR;
      end else begin
        next_state = GRANT_M1_RD;
      end
    end else if (req1w) begin
      next_state = GRANT_M1_WR;
    end else if (req1r) begin
      next_state = GRANT_M1_RD;
    end else if (req0) begin
      next_state = GRANT_M0_RD;
    end else begin
      next_state = IDLE;
    end
  end
`else
  // Fixed priority: M1 write, then M1 read, then M0 read
  always_comb begin
    next_state = IDLE;
    if (req1w) begin
      next_state = GRANT_M1_WR;
    end else if (req1r) begin
      next_state = GRANT_M1_RD;
    end else if (req0) begin
      next_state = GRANT_M0_RD;
    end else begin
      next_state = IDLE;
    end
  end
`endif

endmodule

// File: rtl/ysyx_25020037_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4 arbiter.
// Serialises transactions so the slave sees at most one at a time and
// routes responses back to the granted master only.
// Optional feature macro: ARB_RR_EN (round-robin arbitration).
module ysyx_25020037_axi_arbiter
  import ysyx_25020037_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  // M0 (IFU) read
  input  logic                m0_arvalid,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [3:0]          m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_arready,
  output logic                m0_rvalid,
  output logic [1:0]          m0_rresp,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rlast,
  output logic [3:0]          m0_rid,
  input  logic                m0_rready,
  // M1 (LSU) read
  input  logic                m1_arvalid,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [3:0]          m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_arready,
  output logic                m1_rvalid,
  output logic [1:0]          m1_rresp,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rlast,
  output logic [3:0]          m1_rid,
  input  logic                m1_rready,
  // M1 (LSU) write
  input  logic                m1_awvalid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [3:0]          m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  output logic                m1_awready,
  input  logic                m1_wvalid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  output logic                m1_wready,
  output logic                m1_bvalid,
  output logic [1:0]          m1_bresp,
  output logic [3:0]          m1_bid,
  input  logic                m1_bready,
  // Slave side
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [3:0]          s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_arready,
  input  logic                s_rvalid,
  input  logic [1:0]          s_rresp,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rlast,
  input  logic [3:0]          s_rid,
  output logic                s_rready,
  output logic                s_awvalid,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [3:0]          s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  input  logic                s_awready,
  output logic                s_wvalid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  input  logic                s_wready,
  input  logic                s_bvalid,
  input  logic [1:0]          s_bresp,
  input  logic [3:0]          s_bid,
  output logic                s_bready
);

  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic [1:0] pick_state_s;
  logic       ar_done_r;
  logic       aw_done_r;
  logic       w_done_r;
  logic       ar_hs_s;
  logic       aw_hs_s;
  logic       w_hs_s;
  logic       grant_end_s;

`ifdef ARB_RR_EN
  logic       last_grant_r;
`endif

  ysyx_25020037_arb_pick u_pick (
`ifdef ARB_RR_EN
    .last_grant (last_grant_r),
`endif
    .req0       (m0_arvalid),
    .req1r      (m1_arvalid),
    .req1w      (m1_awvalid),
    .next_state (pick_state_s)
  );

  // Handshakes as seen on the slave side; readys are gated by state,
  // so each term can only fire inside its own grant
  assign ar_hs_s     = s_arvalid & s_arready;
  assign aw_hs_s     = s_awvalid & s_awready;
  assign w_hs_s      = s_wvalid & s_wready;
  assign grant_end_s = (s_rvalid & s_rready & s_rlast) | (s_bvalid & s_bready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: arbitrate in IDLE, hold grant until its final handshake
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:        state_next_s = pick_state_s;
      GRANT_M0_RD,
      GRANT_M1_RD,
      GRANT_M1_WR: state_next_s = grant_end_s ? IDLE : state_r;
      default:     state_next_s = IDLE;
    endcase
  end

  // Done flags: remember completed address/data handshakes within a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_done_r <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (grant_end_s) begin
      ar_done_r <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      if (ar_hs_s) ar_done_r <= 1'b1;
      if (aw_hs_s) aw_done_r <= 1'b1;
      if (w_hs_s)  w_done_r  <= 1'b1;
    end
  end

`ifdef ARB_RR_EN
  // Record which master finished last for round-robin fairness
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= GNT_M0;
    end else if (grant_end_s) begin
      last_grant_r <= (state_r == GRANT_M0_RD) ? GNT_M0 : GNT_M1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Output mux: connect only the granted master to the slave, all else 0
  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rresp   = RESP_OKAY;
    m0_rdata   = {DATA_W{1'b0}};
    m0_rlast   = 1'b0;
    m0_rid     = 4'h0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rresp   = RESP_OKAY;
    m1_rdata   = {DATA_W{1'b0}};
    m1_rlast   = 1'b0;
    m1_rid     = 4'h0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = RESP_OKAY;
    m1_bid     = 4'h0;
    s_arvalid  = 1'b0;
    s_araddr   = {ADDR_W{1'b0}};
    s_arid     = 4'h0;
    s_arlen    = 8'h00;
    s_arsize   = 3'h0;
    s_arburst  = 2'h0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = {ADDR_W{1'b0}};
    s_awid     = 4'h0;
    s_awlen    = 8'h00;
    s_awsize   = 3'h0;
    s_awburst  = 2'h0;
    s_wvalid   = 1'b0;
    s_wdata    = {DATA_W{1'b0}};
    s_wstrb    = {(DATA_W/8){1'b0}};
    s_wlast    = 1'b0;
    s_bready   = 1'b0;
    case (state_r)
      GRANT_M0_RD: begin
        s_arvalid  = m0_arvalid & ~ar_done_r;
        s_araddr   = m0_araddr;
        s_arid     = m0_arid;
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        m0_arready = s_arready & ~ar_done_r;
        m0_rvalid  = s_rvalid;
        m0_rresp   = s_rresp;
        m0_rdata   = s_rdata;
        m0_rlast   = s_rlast;
        m0_rid     = s_rid;
        s_rready   = m0_rready;
      end
      GRANT_M1_RD: begin
        s_arvalid  = m1_arvalid & ~ar_done_r;
        s_araddr   = m1_araddr;
        s_arid     = m1_arid;
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        m1_arready = s_arready & ~ar_done_r;
        m1_rvalid  = s_rvalid;
        m1_rresp   = s_rresp;
        m1_rdata   = s_rdata;
        m1_rlast   = s_rlast;
        m1_rid     = s_rid;
        s_rready   = m1_rready;
      end
      GRANT_M1_WR: begin
        s_awvalid  = m1_awvalid & ~aw_done_r;
        s_awaddr   = m1_awaddr;
        s_awid     = m1_awid;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        m1_awready = s_awready & ~aw_done_r;
        s_wvalid   = m1_wvalid & ~w_done_r;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        m1_wready  = s_wready & ~w_done_r;
        // B is only passed once both address and data have been accepted
        m1_bvalid  = s_bvalid & aw_done_r & w_done_r;
        m1_bresp   = s_bresp;
        m1_bid     = s_bid;
        s_bready   = m1_bready & aw_done_r & w_done_r;
      end
      default: begin
        s_arvalid  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Directed self-checking bench for ysyx_25020037_axi_arbiter.
module tb_ysyx_25020037_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0]  m0_arid, m0_rid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0]  m1_arid, m1_rid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready;
  logic        m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_awid, m1_wstrb, m1_bid;
  logic [7:0]  m1_awlen;
  logic [2:0]  m1_awsize;
  logic [1:0]  m1_awburst, m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
  logic        s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_awid, s_wstrb, s_bid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst, s_bresp;

  int n_cmp = 0;
  int n_bad = 0;
  int ar_hs_cnt = 0;

  ysyx_25020037_axi_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
    .m0_rid(m0_rid), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rresp(m1_rresp), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
    .m1_rid(m1_rid), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
    .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
    .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  // Count AR handshakes seen by the slave
  always @(posedge clk) begin
    if (s_arvalid && s_arready) ar_hs_cnt <= ar_hs_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_arvalid = 1'b0; m0_araddr = 32'h0; m0_arid = 4'h0; m0_arlen = 8'h0;
    m0_arsize = 3'd2; m0_arburst = 2'd1; m0_rready = 1'b0;
    m1_arvalid = 1'b0; m1_araddr = 32'h0; m1_arid = 4'h0; m1_arlen = 8'h0;
    m1_arsize = 3'd2; m1_arburst = 2'd1; m1_rready = 1'b0;
    m1_awvalid = 1'b0; m1_awaddr = 32'h0; m1_awid = 4'h0; m1_awlen = 8'h0;
    m1_awsize = 3'd2; m1_awburst = 2'd1;
    m1_wvalid = 1'b0; m1_wdata = 32'h0; m1_wstrb = 4'h0; m1_wlast = 1'b0; m1_bready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rresp = 2'b00; s_rdata = 32'h0; s_rlast = 1'b0;
    s_rid = 4'h0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
    s_bid = 4'h0;
  endtask

  // Serve a read whose grant is active this cycle, with arready tied high
  task automatic serve_read(input int m, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] id);
    logic [1:0] exp_st;
    int base;
    exp_st = (m == 0) ? 2'd1 : 2'd2;
    s_arready = 1'b1;
    #1;
    n_cmp++;
    if (dut.state_r !== exp_st) begin
      n_bad++; $display("FAIL grant_state m%0d: got %0d want %0d", m, dut.state_r, exp_st);
    end
    n_cmp++;
    if ({s_arvalid, s_araddr, s_arid} !== {1'b1, addr, id}) begin
      n_bad++; $display("FAIL s_ar_fwd m%0d: got %b/%h/%h want 1/%h/%h", m, s_arvalid, s_araddr, s_arid, addr, id);
    end
    n_cmp++;
    if ({m0_arready, m1_arready} !== ((m == 0) ? 2'b10 : 2'b01)) begin
      n_bad++; $display("FAIL arready_route m%0d: got %b%b", m, m0_arready, m1_arready);
    end
    base = ar_hs_cnt;
    step();
    // master keeps arvalid up one more cycle: the forwarded valid must stay masked
    #1;
    n_cmp++;
    if ({s_arvalid, m0_arready, m1_arready} !== 3'b000) begin
      n_bad++; $display("FAIL ar_mask m%0d: got %b%b%b want 000", m, s_arvalid, m0_arready, m1_arready);
    end
    if (m == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = data; s_rlast = 1'b1; s_rid = id; s_rresp = 2'b00;
    m0_rready = 1'b1; m1_rready = 1'b1;
    #1;
    n_cmp++;
    if (m == 0) begin
      if ({m0_rvalid, m0_rdata, m0_rid, m0_rlast, m1_rvalid} !== {1'b1, data, id, 1'b1, 1'b0}) begin
        n_bad++; $display("FAIL r_route m0: got %b/%h/%h m1_rvalid=%b want 1/%h/%h 0", m0_rvalid, m0_rdata, m0_rid, m1_rvalid, data, id);
      end
    end else begin
      if ({m1_rvalid, m1_rdata, m1_rid, m1_rlast, m0_rvalid} !== {1'b1, data, id, 1'b1, 1'b0}) begin
        n_bad++; $display("FAIL r_route m1: got %b/%h/%h m0_rvalid=%b want 1/%h/%h 0", m1_rvalid, m1_rdata, m1_rid, m0_rvalid, data, id);
      end
    end
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    #1;
    n_cmp++;
    if (dut.state_r !== 2'd0) begin
      n_bad++; $display("FAIL release m%0d: state got %0d want 0", m, dut.state_r);
    end
    n_cmp++;
    if (ar_hs_cnt - base !== 1) begin
      n_bad++; $display("FAIL ar_hs_count m%0d: got %0d want 1", m, ar_hs_cnt - base);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    m0_arvalid = 1'b1; m1_awvalid = 1'b1;
    step(); step();
    n_cmp++;
    if ({m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
         s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 12'h000) begin
      n_bad++; $display("FAIL reset_handshake_outs: some ready/valid nonzero");
    end
    n_cmp++;
    if ({dut.state_r, dut.ar_done_r, dut.aw_done_r, dut.w_done_r, s_araddr} !== 37'h0) begin
      n_bad++; $display("FAIL reset_state: state=%0d araddr=%h want 0", dut.state_r, s_araddr);
    end
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_m0_read();
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; m0_arid = 4'h2;
    #1;
    n_cmp++;
    if ({s_arvalid, m0_arready, dut.state_r} !== 4'b0000) begin
      n_bad++; $display("FAIL m0_idle_cycle: s_arvalid=%b arready=%b state=%0d want 0", s_arvalid, m0_arready, dut.state_r);
    end
    step();
    serve_read(0, 32'h8000_0000, 32'h0000_0413, 4'h2);
  endtask

  task automatic test_m1_write();
    m1_awvalid = 1'b1; m1_awaddr = 32'h8000_1000; m1_awid = 4'h5; s_awready = 1'b1;
    step();
    #1;
    n_cmp++;
    if ({dut.state_r, s_awvalid, s_awaddr, m1_awready, s_wvalid} !== {2'd3, 1'b1, 32'h8000_1000, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL aw_fwd: state=%0d awvalid=%b awaddr=%h awready=%b wvalid=%b", dut.state_r, s_awvalid, s_awaddr, m1_awready, s_wvalid);
    end
    step();
    m1_awvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00; s_bid = 4'h5; m1_bready = 1'b1;
    #1;
    n_cmp++;
    if ({s_awvalid, s_wvalid, m1_bvalid, s_bready} !== 4'b0000) begin
      n_bad++; $display("FAIL early_b_held: awv=%b wv=%b bvalid=%b bready=%b want 0000", s_awvalid, s_wvalid, m1_bvalid, s_bready);
    end
    step();
    m1_wvalid = 1'b1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wlast = 1'b1; s_wready = 1'b1;
    #1;
    n_cmp++;
    if ({s_wvalid, s_wdata, s_wstrb, s_wlast, m1_wready, m1_bvalid} !== {1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL w_fwd: wvalid=%b wdata=%h strb=%h wready=%b bvalid=%b", s_wvalid, s_wdata, s_wstrb, m1_wready, m1_bvalid);
    end
    step();
    m1_wvalid = 1'b0;
    #1;
    n_cmp++;
    if ({m1_bvalid, m1_bresp, m1_bid, s_bready, s_wvalid} !== {1'b1, 2'b00, 4'h5, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL b_fwd: bvalid=%b bresp=%b bid=%h bready=%b want 1/00/5/1", m1_bvalid, m1_bresp, m1_bid, s_bready);
    end
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if (dut.state_r !== 2'd0) begin
      n_bad++; $display("FAIL write_release: state got %0d want 0", dut.state_r);
    end
  endtask

  task automatic test_priority();
    int first;
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0010; m0_arid = 4'h1;
    m1_arvalid = 1'b1; m1_araddr = 32'h8000_2000; m1_arid = 4'h7;
`ifdef ARB_RR_EN
    first = 0;
`else
    first = 1;
`endif
    step();
    if (first == 0) serve_read(0, 32'h8000_0010, 32'h1111_0000, 4'h1);
    else            serve_read(1, 32'h8000_2000, 32'h2222_0000, 4'h7);
    step();
    if (first == 0) serve_read(1, 32'h8000_2000, 32'h2222_0000, 4'h7);
    else            serve_read(0, 32'h8000_0010, 32'h1111_0000, 4'h1);
    clear_inputs();
  endtask

  task automatic test_burst();
    logic [31:0] exp;
    m1_arvalid = 1'b1; m1_araddr = 32'h8000_3000; m1_arid = 4'h9; m1_arlen = 8'd3;
    s_arready = 1'b1;
    step();
    #1;
    n_cmp++;
    if ({s_arvalid, s_arlen} !== {1'b1, 8'd3}) begin
      n_bad++; $display("FAIL burst_ar: arvalid=%b arlen=%0d want 1/3", s_arvalid, s_arlen);
    end
    step();
    m1_arvalid = 1'b0; s_arready = 1'b0; m1_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'hA0A0_0000 + i;
      s_rvalid = 1'b1; s_rdata = exp; s_rlast = (i == 3); s_rid = 4'h9;
      #1;
      n_cmp++;
      if ({m1_rvalid, m1_rdata, m1_rlast} !== {1'b1, exp, (i == 3)}) begin
        n_bad++; $display("FAIL burst_beat%0d: got %b/%h/%b want 1/%h/%b", i, m1_rvalid, m1_rdata, m1_rlast, exp, (i == 3));
      end
      step();
      n_cmp++;
      if (dut.state_r !== ((i == 3) ? 2'd0 : 2'd2)) begin
        n_bad++; $display("FAIL burst_hold%0d: state got %0d", i, dut.state_r);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_write();
    m1_awvalid = 1'b1; m1_awaddr = 32'h8000_4000; s_awready = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m1_awready, m1_wready, s_awvalid, s_wvalid, s_bready, dut.state_r, dut.aw_done_r} !== 7'h00) begin
      n_bad++; $display("FAIL mid_reset: awready=%b awvalid=%b state=%0d aw_done=%b want 0", m1_awready, s_awvalid, dut.state_r, dut.aw_done_r);
    end
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
    test_m0_read();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_m0_read();
    step();
    test_m1_write();
    step();
    test_priority();
    step();
    test_burst();
    step();
    test_reset_mid_write();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
